// File: rtl/qtable_pkg.sv
// Shared definitions for the Q-table transmit path: word width, packet types,
// header layout and the FSM state encodings.
package qtable_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [2:0] PKT_HELLO      = 3'd1;
  localparam logic [2:0] PKT_CHANNOUNCE = 3'd2;
  localparam logic [2:0] PKT_DATA       = 3'd3;

  // Header word: {pktType, 5'b0, LEN[7:0]}
  localparam int HDR_TYPE_LSB  = 13;
  localparam int HDR_TYPE_BITS = 3;
  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_BITS  = 8;

  // Words following the header: myID, myHops, myClusterID, myEnergy, bestQ
  localparam int FIELD_WORDS = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HDR,
    ST_FIELDS,
    ST_KCH_RD,
    ST_KCH_WAIT,
    ST_KCH_TX,
    ST_CSUM,
    ST_DONE
  } txState_t;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_READ,
    SC_CMP
  } scanState_t;

  function automatic logic [WORD_WIDTH-1:0] makeHeader(input logic [2:0] pktType,
                                                       input logic [7:0] len);
    logic [WORD_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[HDR_TYPE_LSB +: HDR_TYPE_BITS] = pktType;
    hdr[HDR_LEN_LSB +: HDR_LEN_BITS]   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/qtable_max_scan.sv
// Sequential maximum-Q search over the neighbour table: one read and one
// compare per entry, ties resolved in favour of the lowest index.
module qtable_max_scan
  import qtable_pkg::*;
#(
  parameter int                    MAX_NEIGHBORS = 32,
  parameter logic [WORD_WIDTH-1:0] INIT_Q        = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            count,
  input  logic [WORD_WIDTH-1:0]            mSourceID,
  input  logic [WORD_WIDTH-1:0]            mQValue,
  output logic                             rdEn,
  output logic [$clog2(MAX_NEIGHBORS)-1:0] rdAddr,
  output logic [WORD_WIDTH-1:0]            bestQ,
  output logic [WORD_WIDTH-1:0]            bestID,
  output logic                             done
);

  scanState_t            state, nextState;
  logic [WORD_WIDTH-1:0] idx;
  logic [WORD_WIDTH-1:0] cnt;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SC_IDLE;
    else     state <= nextState;
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    rdEn      = 1'b0;
    rdAddr    = '0;
    done      = 1'b0;
    case (state)
      SC_IDLE: if (start) nextState = SC_READ;
      SC_READ: begin
        if (idx == cnt) begin
          done      = 1'b1;
          nextState = SC_IDLE;
        end else begin
          rdEn      = 1'b1;
          rdAddr    = idx[$clog2(MAX_NEIGHBORS)-1:0];
          nextState = SC_CMP;
        end
      end
      SC_CMP:  nextState = SC_READ;
      default: nextState = SC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      cnt    <= '0;
      bestQ  <= INIT_Q;
      bestID <= '0;
    end else if (start && state == SC_IDLE) begin
      idx    <= '0;
      cnt    <= count;
      bestQ  <= INIT_Q;
      bestID <= '0;
    end else if (state == SC_CMP) begin
      // Strict '>' keeps the earliest entry on a tie
      if (idx == '0 || mQValue > bestQ) begin
        bestQ  <= mQValue;
        bestID <= mSourceID;
      end
      idx <= idx + WORD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/qtable_packet_tx.sv
// Builds and streams the node's cluster/Q-value packet over valid/ready.
// Define QTX_CHECKSUM_EN to append an XOR checksum word to every packet.
module qtable_packet_tx
  import qtable_pkg::*;
#(
  parameter int                    MAX_NEIGHBORS = 32,
  parameter int                    MAX_KCH       = 8,
  parameter logic [WORD_WIDTH-1:0] INIT_Q        = 16'h0000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2:0]                       pktType,
  input  logic [WORD_WIDTH-1:0]            myID,
  input  logic [WORD_WIDTH-1:0]            myHops,
  input  logic [WORD_WIDTH-1:0]            myClusterID,
  input  logic [WORD_WIDTH-1:0]            myEnergy,
  input  logic [WORD_WIDTH-1:0]            mNeighborCount,
  input  logic [WORD_WIDTH-1:0]            mKnownCHCount,
  output logic                             rd_en,
  output logic                             rd_sel,
  output logic [$clog2(MAX_NEIGHBORS)-1:0] rd_addr,
  input  logic [WORD_WIDTH-1:0]            mSourceID,
  input  logic [WORD_WIDTH-1:0]            mQValue,
  input  logic [WORD_WIDTH-1:0]            mKnownCH,
  output logic [WORD_WIDTH-1:0]            tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             tx_last,
  output logic                             busy,
  output logic [WORD_WIDTH-1:0]            bestID,
  output logic                             done
);

  localparam int AW = $clog2(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] MAX_N_W = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] MAX_K_W = WORD_WIDTH'(MAX_KCH);
`ifdef QTX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  txState_t              state, nextState;
  logic [2:0]            pktTypeR;
  logic [WORD_WIDTH-1:0] myIDR, myHopsR, myClusterR, myEnergyR;
  logic [WORD_WIDTH-1:0] kCnt, chIdx, csum, bestQ;
  logic [WORD_WIDTH-1:0] nClamp, kClamp, loadData, nextFieldWord;
  logic [2:0]            fieldIdx;
  logic [7:0]            pktLen;
  logic [AW-1:0]         scanRdAddr;
  logic accept, startOk, scanDone, scanRdEn, chRdEn, lastCh;
  logic loadWord, loadLast, loadCsumWord, advField, advCh;

  assign accept  = tx_valid && tx_ready;
  assign startOk = (state == ST_IDLE) && start;
  assign nClamp  = (mNeighborCount > MAX_N_W) ? MAX_N_W : mNeighborCount;
  assign kClamp  = (mKnownCHCount  > MAX_K_W) ? MAX_K_W : mKnownCHCount;
  assign pktLen  = 8'd6 + kCnt[7:0] + {7'd0, CSUM_EN};
  assign lastCh  = (chIdx == kCnt - WORD_WIDTH'(1));
  assign chRdEn  = (state == ST_KCH_RD);

  assign rd_en   = scanRdEn | chRdEn;
  assign rd_sel  = chRdEn;
  assign rd_addr = chRdEn ? chIdx[AW-1:0] : scanRdAddr;
  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);

  qtable_max_scan #(
    .MAX_NEIGHBORS(MAX_NEIGHBORS),
    .INIT_Q       (INIT_Q)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .start    (startOk),
    .count    (nClamp),
    .mSourceID(mSourceID),
    .mQValue  (mQValue),
    .rdEn     (scanRdEn),
    .rdAddr   (scanRdAddr),
    .bestQ    (bestQ),
    .bestID   (bestID),
    .done     (scanDone)
  );

  // Word that follows the one currently indexed by fieldIdx
  always_comb begin
    case (fieldIdx)
      3'd1:    nextFieldWord = myHopsR;
      3'd2:    nextFieldWord = myClusterR;
      3'd3:    nextFieldWord = myEnergyR;
      default: nextFieldWord = bestQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState    = state;
    loadWord     = 1'b0;
    loadData     = '0;
    loadLast     = 1'b0;
    loadCsumWord = 1'b0;
    advField     = 1'b0;
    advCh        = 1'b0;
    case (state)
      ST_IDLE: if (start) nextState = ST_SCAN;
      ST_SCAN: if (scanDone) begin
        loadWord  = 1'b1;
        loadData  = makeHeader(pktTypeR, pktLen);
        nextState = ST_HDR;
      end
      ST_HDR: if (accept) begin
        loadWord  = 1'b1;
        loadData  = myIDR;
        advField  = 1'b1;
        nextState = ST_FIELDS;
      end
      ST_FIELDS: if (accept) begin
        if (fieldIdx != 3'(FIELD_WORDS)) begin
          loadWord = 1'b1;
          loadData = nextFieldWord;
          loadLast = (fieldIdx == 3'(FIELD_WORDS - 1)) && (kCnt == '0) && !CSUM_EN;
          advField = 1'b1;
        end else if (kCnt != '0) begin
          nextState = ST_KCH_RD;
        end else if (CSUM_EN) begin
          loadWord     = 1'b1;
          loadData     = csum;
          loadLast     = 1'b1;
          loadCsumWord = 1'b1;
          nextState    = ST_CSUM;
        end else begin
          nextState = ST_DONE;
        end
      end
      ST_KCH_RD: nextState = ST_KCH_WAIT;
      ST_KCH_WAIT: begin
        loadWord  = 1'b1;
        loadData  = mKnownCH;
        loadLast  = lastCh && !CSUM_EN;
        nextState = ST_KCH_TX;
      end
      ST_KCH_TX: if (accept) begin
        advCh = 1'b1;
        if (!lastCh) begin
          nextState = ST_KCH_RD;
        end else if (CSUM_EN) begin
          loadWord     = 1'b1;
          loadData     = csum;
          loadLast     = 1'b1;
          loadCsumWord = 1'b1;
          nextState    = ST_CSUM;
        end else begin
          nextState = ST_DONE;
        end
      end
      ST_CSUM: if (accept) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pktTypeR   <= '0;
      myIDR      <= '0;
      myHopsR    <= '0;
      myClusterR <= '0;
      myEnergyR  <= '0;
      kCnt       <= '0;
      fieldIdx   <= '0;
      chIdx      <= '0;
      csum       <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_last    <= 1'b0;
    end else begin
      if (startOk) begin
        pktTypeR   <= pktType;
        myIDR      <= myID;
        myHopsR    <= myHops;
        myClusterR <= myClusterID;
        myEnergyR  <= myEnergy;
        kCnt       <= kClamp;
        fieldIdx   <= '0;
        chIdx      <= '0;
        csum       <= '0;
      end
      if (advField) fieldIdx <= fieldIdx + 3'd1;
      if (advCh)    chIdx    <= chIdx + WORD_WIDTH'(1);
      // The output register only changes on a load or when its word is taken
      if (loadWord) begin
        tx_valid <= 1'b1;
        tx_data  <= loadData;
        tx_last  <= loadLast;
        if (!loadCsumWord) csum <= csum ^ loadData;
      end else if (accept) begin
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
      end
    end
  end

endmodule
